axil_write_resp_ctrl: RTL and testbench

AXI-Lite write-path controller for the register station, sitting directly downstream of the protocol checker. It accepts the AW and W channels independently and joins them into a single register write. It samples the checker's `err_awrite_o`/`err_write_o` flags at each handshake. It then issues a one-cycle register-write strobe, or suppresses it on error, and returns the B response with OKAY or SLVERR.

---
 rtl/axil_write_resp_ctrl.sv | 116 +++++++++++
 tb/tb_axil_write_resp_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axil_write_resp_ctrl.sv
// axil_write_resp_ctrl: joins AXI-Lite AW/W into one register write strobe and returns B (OKAY/SLVERR).
// Optional AXIL_PROT_CHECK_EN rejects unprivileged writes (awprot[0] == 0) with SLVERR.
module axil_write_resp_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   input  logic                      err_awrite_i,
   input  logic                      err_write_i,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic                      reg_wr_en_o,
   output logic [ADDR_WIDTH-1:0]     reg_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     reg_wr_data_o,
   output logic [DATA_WIDTH/8-1:0]   reg_wr_strb_o
);
   typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
   state_t                  state_q, state_d;
   logic                    awready_q, awready_d, wready_q, wready_d;
   logic                    aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic                    aw_err_q, aw_err_d, w_err_q, w_err_d, prot_err_q, prot_err_d;
   logic                    bvalid_q, bvalid_d, wr_en_q, wr_en_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
   logic                    aw_hs, w_hs, b_hs, prot_bad;
`ifdef AXIL_PROT_CHECK_EN
   assign prot_bad = ~s_axi_awprot[0];
`else
   logic unused_prot;
   assign unused_prot = ^s_axi_awprot;
   assign prot_bad    = 1'b0;
`endif
   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid & wready_q;
   assign b_hs  = bvalid_q & s_axi_bready;
   always_comb begin
      addr_d     = aw_hs ? s_axi_awaddr : addr_q;
      data_d     = w_hs ? s_axi_wdata : data_q;
      strb_d     = w_hs ? s_axi_wstrb : strb_q;
      aw_full_d  = b_hs ? 1'b0 : (aw_full_q | aw_hs);
      w_full_d   = b_hs ? 1'b0 : (w_full_q | w_hs);
      aw_err_d   = b_hs ? 1'b0 : (aw_hs ? err_awrite_i : aw_err_q);
      w_err_d    = b_hs ? 1'b0 : (w_hs ? err_write_i : w_err_q);
      prot_err_d = b_hs ? 1'b0 : (aw_hs ? prot_bad : prot_err_q);
      state_d    = state_q;
      wr_en_d    = 1'b0;
      bresp_d    = bresp_q;
      bvalid_d   = bvalid_q & ~s_axi_bready;
      if (state_q == IDLE && aw_full_d && w_full_d) begin
         state_d = WRITE;
         wr_en_d = ~(aw_err_d | w_err_d | prot_err_d);
      end else if (state_q == WRITE) begin
         state_d  = RESP;
         bvalid_d = 1'b1;
         bresp_d  = (aw_err_q | w_err_q | prot_err_q) ? 2'b10 : 2'b00;
      end else if (state_q == RESP && b_hs) begin
         state_d = IDLE;
      end
      // readies follow the registered state, so they return one cycle after re-entering IDLE
      awready_d  = (state_q == IDLE) & ~aw_full_d & ~(aw_full_d & w_full_d);
      wready_d   = (state_q == IDLE) & ~w_full_d & ~(aw_full_d & w_full_d);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         aw_full_q  <= 1'b0;
         w_full_q   <= 1'b0;
         aw_err_q   <= 1'b0;
         w_err_q    <= 1'b0;
         prot_err_q <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
      end else begin
         state_q    <= state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         aw_full_q  <= aw_full_d;
         w_full_q   <= w_full_d;
         aw_err_q   <= aw_err_d;
         w_err_q    <= w_err_d;
         prot_err_q <= prot_err_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         strb_q     <= strb_d;
      end
   end
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign reg_wr_en_o   = wr_en_q;
   assign reg_wr_addr_o = addr_q;
   assign reg_wr_data_o = data_q;
   assign reg_wr_strb_o = strb_q;
endmodule

// File: tb/tb_axil_write_resp_ctrl.sv
// tb_axil_write_resp_ctrl: directed vector table plus hand sequences for stall and mid-transaction reset.
module tb_axil_write_resp_ctrl;
   logic        clk = 1'b0, rst_ni = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0;
   logic [2:0]  awprot = 3'b001;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, err_aw = 1'b0, err_w = 1'b0, bready = 1'b0;
   logic        awready, wready, bvalid, wr_en;
   logic [1:0]  bresp;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   int          checks = 0, failures = 0;
`ifdef AXIL_PROT_CHECK_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        aw_err;
      logic        w_err;
      logic [2:0]  prot;
      int          gap;
      logic        exp_en;
      logic [1:0]  exp_bresp;
   } vec_t;
   vec_t vecs[6];
   always #5 clk = ~clk;
   axil_write_resp_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .err_awrite_i(err_aw), .err_write_i(err_w),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .reg_wr_en_o(wr_en), .reg_wr_addr_o(wr_addr), .reg_wr_data_o(wr_data), .reg_wr_strb_o(wr_strb)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ready();
      int n = 0;
      while (!(awready === 1'b1 && wready === 1'b1) && n < 20) begin
         tick();
         n++;
      end
      chk("ready_timeout", {31'b0, awready === 1'b1 && wready === 1'b1}, 32'd1);
   endtask
   task automatic drive_aw(input vec_t v);
      awaddr = v.addr; awprot = v.prot; err_aw = v.aw_err; awvalid = 1'b1;
   endtask
   task automatic drive_w(input vec_t v);
      wdata = v.data; wstrb = v.strb; err_w = v.w_err; wvalid = 1'b1;
   endtask
   // Leaves the bench in cycle N+2 (bvalid expected high) after checking N+1.
   task automatic run_vec(input vec_t v, input logic br);
      wait_ready();
      bready = br;
      if (v.gap > 0) begin
         drive_w(v);
         tick();
         wvalid = 1'b0;
         chk("wready_drop", {31'b0, wready}, 32'd0);
         chk("awready_hold", {31'b0, awready}, 32'd1);
         repeat (v.gap - 1) tick();
         chk("wready_low", {31'b0, wready}, 32'd0);
         drive_aw(v);
      end else begin
         drive_aw(v);
         drive_w(v);
      end
      tick();
      awvalid = 1'b0; wvalid = 1'b0; err_aw = 1'b0; err_w = 1'b0;
      chk("wr_en_n1", {31'b0, wr_en}, {31'b0, v.exp_en});
      chk("wr_addr", wr_addr, v.addr);
      chk("wr_data", wr_data, v.data);
      chk("wr_strb", {28'b0, wr_strb}, {28'b0, v.strb});
      chk("bvalid_n1", {31'b0, bvalid}, 32'd0);
      tick();
      chk("bvalid_n2", {31'b0, bvalid}, 32'd1);
      chk("bresp_n2", {30'b0, bresp}, {30'b0, v.exp_bresp});
      chk("wr_en_n2", {31'b0, wr_en}, 32'd0);
   endtask
   initial begin
      vecs[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 3'b001, 0, 1'b1, 2'b00};
      vecs[1] = '{32'h20, 32'h12345678, 4'h3, 1'b0, 1'b0, 3'b001, 3, 1'b1, 2'b00};
      vecs[2] = '{32'h13, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 3'b001, 0, 1'b0, 2'b10};
      vecs[3] = '{32'h24, 32'h0BADF00D, 4'h0, 1'b0, 1'b1, 3'b001, 1, 1'b0, 2'b10};
      vecs[4] = '{32'h40, 32'h55AA55AA, 4'hC, 1'b0, 1'b0, 3'b000, 0, !PROT, PROT ? 2'b10 : 2'b00};
      vecs[5] = '{32'h44, 32'hA5A5A5A5, 4'h1, 1'b0, 1'b0, 3'b011, 2, 1'b1, 2'b00};
      #12;
      chk("rst_awready", {31'b0, awready}, 32'd0);
      chk("rst_wready", {31'b0, wready}, 32'd0);
      chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
      chk("rst_bresp", {30'b0, bresp}, 32'd0);
      chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("rst_addr", wr_addr, 32'd0);
      chk("rst_data", wr_data, 32'd0);
      chk("rst_strb", {28'b0, wr_strb}, 32'd0);
      rst_ni = 1'b1;
      tick();
      chk("ready_after_rst", {30'b0, awready, wready}, 32'd3);
      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], 1'b1);
         tick();
         chk("bvalid_n3", {31'b0, bvalid}, 32'd0);
         chk("awready_n3", {31'b0, awready}, 32'd0);
         tick();
         chk("ready_n4", {30'b0, awready, wready}, 32'd3);
      end
      // B stall: error response must stay put and a new AW must be ignored
      run_vec('{32'h13, 32'h11112222, 4'hF, 1'b1, 1'b0, 3'b001, 0, 1'b0, 2'b10}, 1'b0);
      awaddr = 32'h99; awvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall_bvalid", {31'b0, bvalid}, 32'd1);
         chk("stall_bresp", {30'b0, bresp}, 32'd2);
         chk("stall_awready", {31'b0, awready}, 32'd0);
         chk("stall_addr", wr_addr, 32'h13);
      end
      awvalid = 1'b0;
      bready = 1'b1;
      tick();
      chk("stall_release_bvalid", {31'b0, bvalid}, 32'd0);
      chk("stall_release_awready", {31'b0, awready}, 32'd0);
      tick();
      chk("stall_ready_back", {30'b0, awready, wready}, 32'd3);
      chk("stall_addr_kept", wr_addr, 32'h13);
      // Reset asserted while in WRITE drops the transaction
      wait_ready();
      drive_aw(vecs[0]);
      drive_w(vecs[0]);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_wr_en", {31'b0, wr_en}, 32'd0);
      chk("async_ready", {30'b0, awready, wready}, 32'd0);
      chk("async_addr", wr_addr, 32'd0);
      chk("async_data", wr_data, 32'd0);
      chk("async_bvalid", {31'b0, bvalid}, 32'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_no_bvalid", {31'b0, bvalid}, 32'd0);
         chk("post_rst_no_wr_en", {31'b0, wr_en}, 32'd0);
      end
      chk("post_rst_ready", {30'b0, awready, wready}, 32'd3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
